// File: rtl/div_caller.sv
// Drives one div_div callee per operand pair; b==0 answered locally. Issue->result 5 cycles, 1 pair per 6 cycles;
// req_ready drops while a call is in flight or the DEPTH-entry result FIFO is full. DIV_CALLER_FLOOR_EN selects floor division.
module div_caller #(
   parameter int A_W   = 128,
   parameter int B_W   = 64,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [A_W-1:0] req_a,
   input  logic [B_W-1:0] req_b,
   output logic           div_ready,
   output logic [A_W-1:0] div_in_a,
   output logic [B_W-1:0] div_in_b,
   input  logic           div_valid,
   output logic           div_accept,
   input  logic [A_W-1:0] div_out_0,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [A_W-1:0] res_q,
   output logic           res_dz,
   output logic           busy
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0]  ONE_P   = 1;
   localparam logic [PW:0]    ONE_C   = 1;
   localparam logic [PW:0]    DEPTH_C = DEPTH[PW:0];
   localparam logic [A_W-1:0] ONE_A   = 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, GUARD, ZERO} state_t;

   state_t         state_q, state_d;
   logic [A_W-1:0] a_q, a_d;
   logic [B_W-1:0] b_q, b_d;
   logic [A_W-1:0] q_q, q_d;
   logic           dr_q, dr_d;
   logic           da_q, da_d;

   logic [A_W:0]   mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PW:0]    count_q;
   logic           push, pop;
   logic [A_W-1:0] q_fix;
   logic [A_W:0]   wdat;
   logic [A_W:0]   head;

   // in_flight is zero whenever the FSM sits in IDLE, so only the occupancy matters here
   assign req_ready  = rst && (state_q == IDLE) && (count_q < DEPTH_C);
   assign div_ready  = dr_q;
   assign div_accept = da_q;
   assign div_in_a   = a_q;
   assign div_in_b   = b_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      dr_d    = 1'b0;
      da_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (req_b == '0) begin
                  state_d = ZERO;
               end else begin
                  a_d     = req_a;
                  b_d     = req_b;
                  dr_d    = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (div_valid) begin
               q_d     = div_out_0;
               da_d    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            a_d     = '0;
            b_d     = '0;
            state_d = GUARD;
         end
         GUARD:   state_d = IDLE;
         ZERO:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         dr_q    <= 1'b0;
         da_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         dr_q    <= dr_d;
         da_q    <= da_d;
      end
   end

`ifdef DIV_CALLER_FLOOR_EN
   logic [A_W+B_W-1:0] prod;
   logic [A_W+B_W-1:0] a_ext;
   // low A_W+B_W bits of an unsigned product of sign-extended operands equal the signed product
   assign prod  = {{B_W{q_q[A_W-1]}}, q_q} * {{A_W{b_q[B_W-1]}}, b_q};
   assign a_ext = {{B_W{a_q[A_W-1]}}, a_q};
   assign q_fix = ((prod != a_ext) && (a_q[A_W-1] != b_q[B_W-1])) ? q_q - ONE_A : q_q;
`else
   assign q_fix = q_q;
`endif

   assign push = (state_q == ACK) || (state_q == ZERO);
   assign pop  = res_valid && res_ready;
   assign wdat = (state_q == ZERO) ? {1'b1, {A_W{1'b0}}} : {1'b0, q_fix};

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdat;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + ONE_P;
         if (pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
         case ({push, pop})
            2'b10:   count_q <= count_q + ONE_C;
            2'b01:   count_q <= count_q - ONE_C;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign res_valid = (count_q != '0);
   assign res_q     = res_valid ? head[A_W-1:0] : '0;
   assign res_dz    = res_valid ? head[A_W] : 1'b0;
   assign busy      = (state_q != IDLE) || res_valid;
endmodule

// File: tb/tb_div_caller.sv
// Directed bench for div_caller with a behavioural div_div callee (valid 2 cycles after start, clears one cycle after accept).
module tb_div_caller;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [127:0] req_a = '0;
   logic [63:0]  req_b = '0;
   logic         div_ready;
   logic [127:0] div_in_a;
   logic [63:0]  div_in_b;
   logic         div_valid;
   logic         div_accept;
   logic [127:0] div_out_0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [127:0] res_q;
   logic         res_dz;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int dr_count = 0;
   logic mon_en = 1'b0;
   logic [128:0] got[$];

`ifdef DIV_CALLER_FLOOR_EN
   localparam logic [127:0] EXP_M7_2 = 128'(-4);
`else
   localparam logic [127:0] EXP_M7_2 = 128'(-3);
`endif

   div_caller dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .div_ready(div_ready), .div_in_a(div_in_a), .div_in_b(div_in_b),
      .div_valid(div_valid), .div_accept(div_accept), .div_out_0(div_out_0),
      .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_dz(res_dz),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] tdiv(input logic [127:0] a, input logic [63:0] b);
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      logic [127:0] mn;
      mn = {1'b1, {127{1'b0}}};
      sa = a;
      sb = {{64{b[63]}}, b};
      if (a == mn && sb == -128'sd1) return a;
      return sa / sb;
   endfunction

   // callee stub sharing the reset net
   logic cal_pend, cal_clr;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cal_pend  <= 1'b0;
         cal_clr   <= 1'b0;
         div_valid <= 1'b0;
         div_out_0 <= '0;
      end else begin
         cal_pend <= div_ready;
         cal_clr  <= div_accept;
         if (cal_pend) div_valid <= 1'b1;
         if (cal_clr)  div_valid <= 1'b0;
         if (div_ready) div_out_0 <= tdiv(div_in_a, div_in_b);
      end
   end

   always @(negedge clk) begin
      if (div_ready === 1'b1) dr_count++;
      if (mon_en && res_valid === 1'b1 && res_ready === 1'b1) got.push_back({res_dz, res_q});
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [127:0] a, input logic [63:0] b);
      int n;
      @(posedge clk); #1;
      req_valid = 1'b1; req_a = a; req_b = b;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (req_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL send_timeout a=%0h b=%0h", a, b);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_res();
      int n;
      n = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (res_valid !== 1'b1) begin
         total++; bad++;
         $display("FAIL res_timeout res_valid=%b required=1", res_valid);
      end
   endtask

   task automatic pop();
      @(posedge clk); #1; res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      total++; if ({div_ready, div_accept, res_valid, res_dz, busy} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {div_ready, div_accept, res_valid, res_dz, busy}); end
      total++; if ({div_in_a, div_in_b, res_q} !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", {div_in_a, div_in_b, res_q}); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_req_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_basic();
      logic [6:1] dr_s, da_s, rv_s, rr_s;
      send(128'd100, 64'd7);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         dr_s[c] = div_ready; da_s[c] = div_accept; rv_s[c] = res_valid; rr_s[c] = req_ready;
      end
      total++; if (dr_s !== 6'b000001) begin bad++; $display("FAIL basic_div_ready got=%b exp=000001", dr_s); end
      total++; if (da_s !== 6'b001000) begin bad++; $display("FAIL basic_div_accept got=%b exp=001000", da_s); end
      total++; if (rv_s !== 6'b110000) begin bad++; $display("FAIL basic_res_valid got=%b exp=110000", rv_s); end
      total++; if (rr_s !== 6'b100000) begin bad++; $display("FAIL basic_req_ready got=%b exp=100000", rr_s); end
      total++; if ({res_dz, res_q} !== {1'b0, 128'd14}) begin bad++; $display("FAIL basic_res got=%0h exp=%0h", {res_dz, res_q}, {1'b0, 128'd14}); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_full got=%b exp=1", busy); end
      pop();
      @(negedge clk);
      total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_after_pop got=%b exp=00", {res_valid, busy}); end
   endtask

   task automatic test_floor();
      send(128'(-7), 64'd2);
      wait_res();
      total++; if ({res_dz, res_q} !== {1'b0, EXP_M7_2}) begin bad++; $display("FAIL floor_m7_2 got=%0h exp=%0h", {res_dz, res_q}, {1'b0, EXP_M7_2}); end
      pop();
      send(128'(-8), 64'd2);
      wait_res();
      total++; if ({res_dz, res_q} !== {1'b0, 128'(-4)}) begin bad++; $display("FAIL floor_m8_2 got=%0h exp=%0h", {res_dz, res_q}, {1'b0, 128'(-4)}); end
      pop();
   endtask

   task automatic test_zero();
      int dr0;
      dr0 = dr_count;
      send(128'd5, 64'd0);
      @(negedge clk);
      total++; if ({res_valid, req_ready, div_in_a != '0} !== 3'b000) begin bad++; $display("FAIL zero_cycle1 got=%b exp=000", {res_valid, req_ready, div_in_a != '0}); end
      @(negedge clk);
      total++; if ({res_valid, req_ready} !== 2'b11) begin bad++; $display("FAIL zero_cycle2 got=%b exp=11", {res_valid, req_ready}); end
      total++; if ({res_dz, res_q} !== {1'b1, 128'd0}) begin bad++; $display("FAIL zero_res got=%0h exp=%0h", {res_dz, res_q}, {1'b1, 128'd0}); end
      total++; if (dr_count !== dr0) begin bad++; $display("FAIL zero_no_call got=%0d exp=%0d", dr_count, dr0); end
      pop();
   endtask

   task automatic test_full();
      logic [128:0] exp_r [5];
      logic held;
      exp_r[0] = {1'b0, 128'd6};
      exp_r[1] = {1'b0, 128'(-7)};
      exp_r[2] = {1'b0, 128'(-3)};
      exp_r[3] = {1'b1, 128'd0};
      exp_r[4] = {1'b0, 128'd100};
      res_ready = 1'b0;
      send(128'd20, 64'd3);
      send(128'(-21), 64'd3);
      send(128'd21, 64'(-7));
      send(128'd9, 64'd0);
      req_valid = 1'b1; req_a = 128'd1000; req_b = 64'd10;
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_ready !== 1'b0) held = 1'b0;
      end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL full_hold got=%b exp=1", held); end
      total++; if ({res_valid, busy} !== 2'b11) begin bad++; $display("FAIL full_valid got=%b exp=11", {res_valid, busy}); end
      pop();
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_accept_after_pop got=%b exp=1", req_ready); end
      @(posedge clk); #1; req_valid = 1'b0;
      for (int i = 1; i < 5; i++) begin
         wait_res();
         total++; if ({res_dz, res_q} !== exp_r[i]) begin bad++; $display("FAIL full_order_%0d got=%0h exp=%0h", i, {res_dz, res_q}, exp_r[i]); end
         pop();
      end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      send(128'd50, 64'd5);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      total++; if ({div_ready, div_accept, res_valid, res_dz, busy, req_ready} !== 6'b0) begin bad++; $display("FAIL mid_rst_flags got=%b exp=000000", {div_ready, div_accept, res_valid, res_dz, busy, req_ready}); end
      total++; if ({div_in_a, div_in_b, res_q} !== '0) begin bad++; $display("FAIL mid_rst_data got=%0h exp=0", {div_in_a, div_in_b, res_q}); end
      @(negedge clk); rst = 1'b1;
      send(128'd77, 64'd7);
      wait_res();
      total++; if ({res_dz, res_q} !== {1'b0, 128'd11}) begin bad++; $display("FAIL mid_rst_res got=%0h exp=%0h", {res_dz, res_q}, {1'b0, 128'd11}); end
      pop();
      repeat (8) @(negedge clk);
      total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL mid_rst_no_stale got=%b exp=00", {res_valid, busy}); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] va [8];
      logic [63:0]  vb [8];
      logic [128:0] ve [8];
      int n;
      va[0] = 128'd100;        vb[0] = 64'd7;     ve[0] = {1'b0, 128'd14};
      va[1] = 128'(-7);        vb[1] = 64'd2;     ve[1] = {1'b0, EXP_M7_2};
      va[2] = 128'd5;          vb[2] = 64'd0;     ve[2] = {1'b1, 128'd0};
      va[3] = {1'b1, 127'd0};  vb[3] = 64'(-1);   ve[3] = {1'b0, 1'b1, 127'd0};
      va[4] = 128'(-8);        vb[4] = 64'd2;     ve[4] = {1'b0, 128'(-4)};
      va[5] = 128'd7;          vb[5] = 64'(-1);   ve[5] = {1'b0, 128'(-7)};
      va[6] = 128'd1;          vb[6] = 64'd0;     ve[6] = {1'b1, 128'd0};
      va[7] = 128'd123456789;  vb[7] = 64'd1000;  ve[7] = {1'b0, 128'd123456};
      got.delete();
      mon_en = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(va[i], vb[i]);
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      res_ready = 1'b0;
      total++; if (got.size() !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= got.size()) begin bad++; $display("FAIL b2b_res_%0d got=none exp=%0h", i, ve[i]); end
         else if (got[i] !== ve[i]) begin bad++; $display("FAIL b2b_res_%0d got=%0h exp=%0h", i, got[i], ve[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_floor();
      test_zero();
      test_full();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div_caller.md
Name: div_caller

Overview:
- Initiator side of the generated-divider call handshake (div_ready / div_valid / div_accept); drives one `div_div` callee instance.
- Takes signed operand pairs from an upstream valid/ready stream and runs one callee transaction per pair.
- Pushes quotients into a small result FIFO toward the downstream consumer.
- Handles divide-by-zero locally without calling the callee.

Parameters:
A_W, 128, dividend and quotient width
B_W, 64, divisor width
DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  upstream operand pair valid
req_ready  out  1  operand pair accepted when req_valid&req_ready
req_a  in  A_W  signed dividend
req_b  in  B_W  signed divisor
div_ready  out  1  callee start strobe
div_in_a  out  A_W  callee dividend
div_in_b  out  B_W  callee divisor
div_valid  in  1  callee result valid
div_accept  out  1  callee result acknowledge
div_out_0  in  A_W  callee quotient
res_valid  out  1  FIFO non-empty
res_ready  in  1  downstream pop
res_q  out  A_W  FIFO head quotient
res_dz  out  1  FIFO head divide-by-zero flag
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (rst low, async):
  - FSM goes to IDLE; FIFO is emptied.
  - div_ready=0, div_accept=0; div_in_a=0, div_in_b=0.
  - res_valid=0, res_q=0, res_dz=0; busy=0.
  - req_ready=0 while rst is low.
  - Reset mid-transaction abandons the call. The callee shares the reset net, so both ends restart clean.
- req_ready = (state==IDLE) && (count + in_flight < DEPTH). Only one transaction is in flight; the FIFO never overflows.
- FSM states (all outputs registered):
  - IDLE: on req handshake, latch a and b.
    - If b==0, go to ZERO.
    - Otherwise drive div_in_a/div_in_b and go to ISSUE.
  - ISSUE: div_ready=1 for exactly this cycle; div_in_a/div_in_b held stable. Go to WAIT.
  - WAIT: div_ready=0. Stay until div_valid==1, then capture div_out_0 into q_reg and go to ACK. No timeout.
  - ACK: div_accept=1 for exactly this cycle. Push {q_reg, dz=0} into the FIFO at the end of the cycle. Go to GUARD.
  - GUARD: one cycle; div_valid is ignored here because the callee's valid clears one cycle late. Go to IDLE.
  - ZERO: push {q=0, dz=1}; callee untouched. Go to IDLE.
- Timing, req handshake at cycle 0, empty FIFO:
  - ISSUE is cycle 1; div_valid is first high at cycle 3; ACK is cycle 4; res_valid rises at cycle 5.
  - Next req_ready is cycle 6, giving 1 pair per 6 cycles.
  - ZERO path: res_valid rises at cycle 2; next req_ready at cycle 2.
- div_in_a/div_in_b are held from ISSUE through ACK; zeroed in GUARD.
- FIFO:
  - Pop when res_valid & res_ready; res_q/res_dz present the head combinationally from storage.
  - Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
  - Pop on empty is ignored.
  - With FIFO full, the FSM stays in IDLE and req_ready=0.
- Arithmetic: quotient passes through unmodified (truncating toward zero) unless the optional feature is enabled.

Optional Feature:
DIV_CALLER_FLOOR_EN
- Defined:
  - In ACK, compute p = q_reg*b (A_W+B_W bits).
  - If p != a and sign(a) != sign(b), the pushed quotient is q_reg-1, giving floor-division (Python //) semantics.
  - Latency is unchanged; the correction is registered into the FIFO write.
- Undefined: no multiplier; the callee quotient is pushed as-is.

Test Plan:
- After reset: req a=100, b=7 -> div_ready pulses 1 cycle at cycle 1; div_accept pulses at cycle 4; res_valid at cycle 5 with res_q=14, res_dz=0; busy drops after pop.
- a=-7, b=2 -> res_q=-3 without DIV_CALLER_FLOOR_EN; res_q=-4 with it. a=-8, b=2 -> -4 in both builds.
- a=5, b=0 -> no div_ready pulse; res_q=0, res_dz=1 at cycle 2.
- res_ready=0 with 4 pairs sent -> 4 entries queued, req_ready stays 0. Pop 1 -> next pair is accepted. Results emerge in order.
- rst low while in WAIT -> all outputs 0 asynchronously. After release, a new pair completes normally with no stale result pushed.
- res_ready=1 continuously over 8 back-to-back pairs including b=0 and b=-1 with a=-2^127 -> ordered results. The stale div_valid in GUARD causes no duplicate push. The wrap-around quotient -2^127 passes through.
